// File: rtl/tiger_proc_slave.sv
// tiger_proc_slave: 16-word processor slave with fixed-latency pipelined reads.
//   R0..R14 : byte-enabled read/write registers
//   R15     : free-running cycle counter (writes ignored)
// Optional build macro PROC_SLAVE_WRITE_STALL_EN: every write is held for one
// wait-state cycle and accepted on its second cycle.
module tiger_proc_slave #(
    parameter int READ_LATENCY = 2,   // 1..4
    parameter int MAX_PENDING  = 4    // READ_LATENCY..8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] avs_procSlave_address,
    input  logic        avs_procSlave_read,
    input  logic        avs_procSlave_write,
    input  logic [31:0] avs_procSlave_writedata,
    input  logic [3:0]  avs_procSlave_byteenable,
    output logic [31:0] avs_procSlave_readdata,
    output logic        avs_procSlave_waitrequest,
    output logic        avs_procSlave_readdatavalid
);

    localparam int PW = 4;

    logic [31:0]       regs [0:14];
    logic [31:0]       cycle_cnt;
    logic [3:0]        idx;
    logic [PW-1:0]     pend_cnt;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0]       pipe_dat [0:READ_LATENCY-1];
    logic [31:0]       rd_sample;
    logic              wr_stall;
    logic              rd_stall;
    logic              wr_acc;
    logic              rd_acc;
    logic              rsp_retire;
    logic              unused_addr;

    assign idx         = avs_procSlave_address[5:2];
    assign unused_addr = ^{avs_procSlave_address[31:6], avs_procSlave_address[1:0]};

`ifdef PROC_SLAVE_WRITE_STALL_EN
    logic wr_flag;

    // Flag marks that the current write has already spent its wait-state cycle.
    // It drops on acceptance, and also if the master abandons the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_flag <= 1'b0;
        end else begin
            wr_flag <= avs_procSlave_write & ~wr_flag;
        end
    end

    assign wr_stall = ~wr_flag;
`else
    assign wr_stall = 1'b0;
`endif

    // A response leaving the last stage frees a slot in this same cycle.
    assign rsp_retire = pipe_vld[READ_LATENCY-1];
    assign rd_stall   = (pend_cnt == PW'(MAX_PENDING)) && !rsp_retire;

    // Write has priority over read; an idle bus never sees waitrequest.
    always_comb begin
        avs_procSlave_waitrequest = 1'b0;
        if (avs_procSlave_write) begin
            avs_procSlave_waitrequest = wr_stall;
        end else if (avs_procSlave_read) begin
            avs_procSlave_waitrequest = rd_stall;
        end
    end

    assign wr_acc = avs_procSlave_write & ~wr_stall;
    assign rd_acc = avs_procSlave_read & ~avs_procSlave_write & ~rd_stall;

    // Read mux: register contents before any write landing on this edge.
    always_comb begin
        rd_sample = cycle_cnt;
        for (int i = 0; i < 15; i++) begin
            if (idx == 4'(i)) begin
                rd_sample = regs[i];
            end
        end
    end

    // Byte-lane writes into R0..R14; R15 is never a write target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_acc) begin
            for (int i = 0; i < 15; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (idx == 4'(i) && avs_procSlave_byteenable[b]) begin
                        regs[i][8*b +: 8] <= avs_procSlave_writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Free-running cycle counter exposed as R15.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Response pipeline; data stages only load behind a valid, so the last
    // stage keeps the most recent response while readdatavalid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= rd_sample;
            end
        end
    end

    // Outstanding-read counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_cnt <= '0;
        end else begin
            case ({rd_acc, rsp_retire})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    assign avs_procSlave_readdata      = pipe_dat[READ_LATENCY-1];
    assign avs_procSlave_readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_tiger_proc_slave.sv
// Testbench for tiger_proc_slave: directed scenarios plus randomized traffic
// checked cycle-by-cycle against a transaction-level reference model.
module tb_tiger_proc_slave;

    localparam int LAT  = 2;
    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;

    always #5 clk = ~clk;

    tiger_proc_slave #(.READ_LATENCY(LAT), .MAX_PENDING(MAXP)) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .avs_procSlave_address       (address),
        .avs_procSlave_read          (read),
        .avs_procSlave_write         (write),
        .avs_procSlave_writedata     (writedata),
        .avs_procSlave_byteenable    (byteenable),
        .avs_procSlave_readdata      (readdata),
        .avs_procSlave_waitrequest   (waitrequest),
        .avs_procSlave_readdatavalid (readdatavalid)
    );

    // Reference model: register array, cycle count since reset release,
    // and a queue of promised responses stamped with their due cycle.
    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic [31:0] m_regs [0:14];
    logic [31:0] m_cnt;
    logic [31:0] m_last;
    rsp_t        m_q[$];
    bit          m_wstalled;
    int          cyc;

    logic [31:0] obs_rsp[$];
    int          obs_rsp_cyc[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        m_cnt      = '0;
        m_last     = '0;
        m_wstalled = 0;
        m_q.delete();
    endtask

    // One bus cycle: drive at posedge+1, check at negedge, advance the model.
    task automatic step(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output bit acc, output bit obs_wait);
        bit          exp_rdv;
        bit          exp_wait;
        bit          wstall;
        int          k;
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = wdata;
        byteenable = be;
        @(negedge clk);
        exp_rdv = (m_q.size() > 0) && (m_q[0].due == cyc);
`ifdef PROC_SLAVE_WRITE_STALL_EN
        wstall = !m_wstalled;
`else
        wstall = 0;
`endif
        if (wr)      exp_wait = wstall;
        else if (rd) exp_wait = (m_q.size() == MAXP) && !exp_rdv;
        else         exp_wait = 0;
        obs_wait = waitrequest;
        check_eq("waitrequest", {31'd0, waitrequest}, {31'd0, exp_wait});
        check_eq("readdatavalid", {31'd0, readdatavalid}, {31'd0, exp_rdv});
        if (exp_rdv) begin
            m_last = m_q[0].data;
            void'(m_q.pop_front());
        end
        check_eq("readdata", readdata, m_last);
        if (readdatavalid) begin
            obs_rsp.push_back(readdata);
            obs_rsp_cyc.push_back(cyc);
        end
        acc = (rd || wr) && !exp_wait;
`ifdef PROC_SLAVE_WRITE_STALL_EN
        m_wstalled = wr && !m_wstalled;
`endif
        k = int'(addr[5:2]);
        if (acc && wr && k != 15) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_regs[k][8*b +: 8] = wdata[8*b +: 8];
        end
        if (acc && !wr) begin
            rsp_t r;
            r.data = (k == 15) ? m_cnt : m_regs[k];
            r.due  = cyc + LAT;
            m_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic idle(input int n);
        bit a, w;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, a, w);
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bit a, w;
        a = 0;
        for (int i = 0; i < 4 && !a; i++) step(0, 1, addr, data, be, a, w);
        check_eq("write_accepted", {31'd0, a}, 32'd1);
    endtask

    task automatic rd_word(input logic [31:0] addr, output logic [31:0] data);
        bit a, w;
        a = 0;
        obs_rsp.delete();
        obs_rsp_cyc.delete();
        for (int i = 0; i < 8 && !a; i++) step(1, 0, addr, '0, '0, a, w);
        check_eq("read_accepted", {31'd0, a}, 32'd1);
        idle(LAT + 1);
        check_eq("read_rsp_count", obs_rsp.size(), 32'd1);
        data = (obs_rsp.size() > 0) ? obs_rsp[0] : 32'hxxxx_xxxx;
    endtask

    task automatic do_reset();
        read = 0; write = 0; address = '0; writedata = '0; byteenable = '0;
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rst_rdv", {31'd0, readdatavalid}, 32'd0);
        check_eq("rst_rdata", readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] cnt_at;
        bit          a, w, prd, pwr;
        int          n_acc;
        logic [31:0] ra, rwd;
        logic [3:0]  rbe;

        cyc = 0;
        model_clear();
        #1;
        do_reset();
        idle(2);

        // Byte-lane merge on R3.
        wr_word(32'h0000_000C, 32'hDEADBEEF, 4'hF);
        wr_word(32'h0000_000C, 32'h0000_0011, 4'h1);
        rd_word(32'h0000_000C, d);
        check_eq("r3_merge", d, 32'hDEADBE11);

        // Back-to-back reads of R1..R4.
        for (int i = 1; i <= 4; i++) wr_word(32'(i * 4), 32'(i), 4'hF);
        obs_rsp.delete();
        obs_rsp_cyc.delete();
        n_acc = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 32'(i * 4), '0, '0, a, w);
            if (a) n_acc++;
            check_eq("b2b_no_wait", {31'd0, w}, 32'd0);
        end
        idle(LAT + 1);
        check_eq("b2b_accepts", n_acc, 32'd4);
        check_eq("b2b_rsp_count", obs_rsp.size(), 32'd4);
        for (int i = 0; i < 4 && i < obs_rsp.size(); i++) begin
            check_eq("b2b_rsp_data", obs_rsp[i], 32'(i + 1));
            if (i > 0) check_eq("b2b_rsp_consec", obs_rsp_cyc[i] - obs_rsp_cyc[i-1], 32'd1);
        end

        // R15 aliasing, counter value, and ignored write.
        wr_word(32'h0000_003C, 32'h12345678, 4'hF);
        cnt_at = m_cnt;
        obs_rsp.delete();
        step(1, 0, 32'h0000_007C, '0, '0, a, w);
        idle(LAT + 1);
        check_eq("r15_rsp_count", obs_rsp.size(), 32'd1);
        if (obs_rsp.size() > 0) check_eq("r15_counter", obs_rsp[0], cnt_at);

        // Write wait-state behaviour on R5.
        step(0, 1, 32'h0000_0014, 32'hA5A5_0505, 4'hF, a, w);
`ifdef PROC_SLAVE_WRITE_STALL_EN
        check_eq("wstall_cycle1", {31'd0, w}, 32'd1);
        step(0, 1, 32'h0000_0014, 32'hA5A5_0505, 4'hF, a, w);
        check_eq("wstall_cycle2", {31'd0, w}, 32'd0);
`else
        check_eq("wnostall_cycle1", {31'd0, w}, 32'd0);
`endif
        idle(1);
        rd_word(32'h0000_0014, d);
        check_eq("r5_written", d, 32'hA5A5_0505);

        // Randomized traffic with aliased addresses and bursty reads.
        prd = 0; pwr = 0; ra = '0; rwd = '0; rbe = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                prd = ($urandom_range(0, 9) < 6);
                pwr = ($urandom_range(0, 9) < 3);
                ra  = $urandom();
                rwd = $urandom();
                rbe = 4'($urandom_range(0, 15));
            end
            step(prd, pwr, ra, rwd, rbe, a, w);
        end
        idle(LAT + 2);

        // Reset with reads in flight: they must vanish, registers clear.
        step(1, 0, 32'h0000_0004, '0, '0, a, w);
        step(1, 0, 32'h0000_0008, '0, '0, a, w);
        obs_rsp.delete();
        do_reset();
        idle(LAT + 3);
        check_eq("rst_no_rsp", obs_rsp.size(), 32'd0);
        for (int i = 0; i < 15; i++) begin
            rd_word(32'(i * 4), d);
            check_eq("rst_reg_zero", d, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
